// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: two-port arbiter and sequencer that time-shares one slow
// combinational ALU. Holds the winning operands for a settle window, then
// captures result and flags and returns them over a valid/ready channel.
module alu_share_ctrl #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned SETTLE     = 4,
    parameter int unsigned MUL_SETTLE = 40
) (
    input  logic             clk,
    input  logic             reset,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_ctrl,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_result,
    output logic [3:0]       resp0_flags,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_ctrl,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_result,
    output logic [3:0]       resp1_flags,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_cout
);

    // Counter only needs to hold the larger settle window minus one.
    localparam int unsigned CNT_MAX = (MUL_SETTLE > SETTLE) ? MUL_SETTLE : SETTLE;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] ALU_LOAD  = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] MUL_LOAD  = CNT_W'(MUL_SETTLE - 1);
    localparam logic [2:0]       OP_MUL    = 3'b100;
    localparam logic [3:0]       ERR_FLAGS = 4'b1000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRIVE = 2'd1,
        S_RESP  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             rr_q, rr_d;
    logic             owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d;
    logic [WIDTH-1:0] alu_b_q, alu_b_d;
    logic [2:0]       alu_ctrl_q, alu_ctrl_d;
    logic [1:0]       resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp0_result_q, resp0_result_d;
    logic [WIDTH-1:0] resp1_result_q, resp1_result_d;
    logic [3:0]       resp0_flags_q, resp0_flags_d;
    logic [3:0]       resp1_flags_q, resp1_flags_d;

    logic             grant0_c, grant1_c;
    logic [WIDTH-1:0] sel_a_c, sel_b_c;
    logic [2:0]       sel_ctrl_c;
    logic             owner_ready_c;
    logic             cap_en_c;
    logic [WIDTH-1:0] cap_result_c;
    logic [3:0]       cap_flags_c;

    // Round-robin grant, only offered while idle; rr breaks ties.
    always_comb begin
        grant0_c = 1'b0;
        grant1_c = 1'b0;
        if (state_q == S_IDLE) begin
            if (req0_valid && req1_valid) begin
                grant0_c = ~rr_q;
                grant1_c = rr_q;
            end else begin
                grant0_c = req0_valid;
                grant1_c = req1_valid;
            end
        end
    end

    // Payload of the granted requester and the current owner's response ready.
    always_comb begin
        sel_a_c       = grant1_c ? req1_a    : req0_a;
        sel_b_c       = grant1_c ? req1_b    : req0_b;
        sel_ctrl_c    = grant1_c ? req1_ctrl : req0_ctrl;
        owner_ready_c = owner_q  ? resp1_ready : resp0_ready;
    end

    // Next-state and datapath updates for the accept / settle / respond sequence.
    always_comb begin
        state_d        = state_q;
        rr_d           = rr_q;
        owner_d        = owner_q;
        cnt_d          = cnt_q;
        alu_a_d        = alu_a_q;
        alu_b_d        = alu_b_q;
        alu_ctrl_d     = alu_ctrl_q;
        resp_valid_d   = resp_valid_q;
        resp0_result_d = resp0_result_q;
        resp1_result_d = resp1_result_q;
        resp0_flags_d  = resp0_flags_q;
        resp1_flags_d  = resp1_flags_q;
        cap_en_c       = 1'b0;
        cap_result_c   = '0;
        cap_flags_c    = '0;

        case (state_q)
            S_IDLE: begin
                if (grant0_c || grant1_c) begin
                    owner_d = grant1_c;
                    rr_d    = ~grant1_c;
                    if (sel_ctrl_c <= OP_MUL) begin
                        alu_a_d    = sel_a_c;
                        alu_b_d    = sel_b_c;
                        alu_ctrl_d = sel_ctrl_c;
                        cnt_d      = (sel_ctrl_c == OP_MUL) ? MUL_LOAD : ALU_LOAD;
                        state_d    = S_DRIVE;
                    end else begin
                        // Unsupported op: answer with err, leave the ALU inputs alone.
                        cap_en_c     = 1'b1;
                        cap_result_c = '0;
                        cap_flags_c  = ERR_FLAGS;
                        state_d      = S_RESP;
                    end
                end
            end
            S_DRIVE: begin
                if (cnt_q == '0) begin
                    cap_en_c     = 1'b1;
                    cap_result_c = alu_out;
                    cap_flags_c  = {1'b0, alu_cout, alu_overflow, alu_zero};
                    state_d      = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (resp_valid_q[owner_q] && owner_ready_c) begin
                    resp_valid_d = '0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (cap_en_c) begin
            if (owner_d) begin
                resp1_result_d  = cap_result_c;
                resp1_flags_d   = cap_flags_c;
                resp_valid_d[1] = 1'b1;
            end else begin
                resp0_result_d  = cap_result_c;
                resp0_flags_d   = cap_flags_c;
                resp_valid_d[0] = 1'b1;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            rr_q           <= 1'b0;
            owner_q        <= 1'b0;
            cnt_q          <= '0;
            alu_a_q        <= '0;
            alu_b_q        <= '0;
            alu_ctrl_q     <= '0;
            resp_valid_q   <= '0;
            resp0_result_q <= '0;
            resp1_result_q <= '0;
            resp0_flags_q  <= '0;
            resp1_flags_q  <= '0;
        end else begin
            state_q        <= state_d;
            rr_q           <= rr_d;
            owner_q        <= owner_d;
            cnt_q          <= cnt_d;
            alu_a_q        <= alu_a_d;
            alu_b_q        <= alu_b_d;
            alu_ctrl_q     <= alu_ctrl_d;
            resp_valid_q   <= resp_valid_d;
            resp0_result_q <= resp0_result_d;
            resp1_result_q <= resp1_result_d;
            resp0_flags_q  <= resp0_flags_d;
            resp1_flags_q  <= resp1_flags_d;
        end
    end

    assign req0_ready   = grant0_c;
    assign req1_ready   = grant1_c;
    assign resp0_valid  = resp_valid_q[0];
    assign resp1_valid  = resp_valid_q[1];
    assign resp0_result = resp0_result_q;
    assign resp1_result = resp1_result_q;
    assign resp0_flags  = resp0_flags_q;
    assign resp1_flags  = resp1_flags_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_ctrl     = alu_ctrl_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: a delayed ALU stand-in, a transaction-level
// reference model, directed scenarios and then randomized two-port traffic.
module tb_alu_share_ctrl;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned SETTLE     = 4;
    localparam int unsigned MUL_SETTLE = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0_valid, req0_ready, resp0_valid, resp0_ready;
    logic [31:0] req0_a, req0_b, resp0_result;
    logic [2:0]  req0_ctrl;
    logic [3:0]  resp0_flags;
    logic        req1_valid, req1_ready, resp1_valid, resp1_ready;
    logic [31:0] req1_a, req1_b, resp1_result;
    logic [2:0]  req1_ctrl;
    logic [3:0]  resp1_flags;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_ctrl;
    logic        alu_zero, alu_overflow, alu_cout;

    always #5 clk = ~clk;

    alu_share_ctrl #(.WIDTH(WIDTH), .SETTLE(SETTLE), .MUL_SETTLE(MUL_SETTLE)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_ctrl(req0_ctrl), .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_result(resp0_result), .resp0_flags(resp0_flags),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_ctrl(req1_ctrl), .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_flags(resp1_flags),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_out(alu_out),
        .alu_zero(alu_zero), .alu_overflow(alu_overflow), .alu_cout(alu_cout)
    );

    // ALU behaviour: returns {err, cout, overflow, zero, result}.
    function automatic logic [35:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] c);
        logic [32:0]        s;
        logic signed [63:0] sa, sb, p;
        logic [31:0]        r;
        logic               co, ov;
        r = '0; co = 1'b0; ov = 1'b0;
        case (c)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; co = s[32];
                ov = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                r = a - b; co = (a < b);
                ov = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a ^ b;
            3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd4: begin
                sa = {{32{a[31]}}, a};
                sb = {{32{b[31]}}, b};
                p  = sa * sb;
                r  = p[31:0];
                ov = (p[63:32] != {32{p[31]}});
            end
            default: r = '0;
        endcase
        return {1'b0, co, ov, (r == 32'd0), r};
    endfunction

    // ALU stand-in whose output lags its inputs by three clocks.
    logic [31:0] ha0 = '0, ha1 = '0, ha2 = '0, hb0 = '0, hb1 = '0, hb2 = '0;
    logic [2:0]  hc0 = '0, hc1 = '0, hc2 = '0;
    logic [35:0] alu_res;
    always @(posedge clk) begin
        ha0 <= alu_a; ha1 <= ha0; ha2 <= ha1;
        hb0 <= alu_b; hb1 <= hb0; hb2 <= hb1;
        hc0 <= alu_ctrl; hc1 <= hc0; hc2 <= hc1;
    end
    assign alu_res      = alu_fn(ha2, hb2, hc2);
    assign alu_out      = alu_res[31:0];
    assign alu_zero     = alu_res[32];
    assign alu_overflow = alu_res[33];
    assign alu_cout     = alu_res[34];

    int checks = 0;
    int errors = 0;

    // Reference model: one transaction in flight with a known completion cycle.
    int          cyc = 0;
    bit          busy = 0, own = 0, rr = 0;
    int          resp_t = 0, acc_cyc = 0;
    logic [31:0] ea = '0, eb = '0;
    logic [2:0]  ec = '0;
    logic [31:0] pres = '0;
    logic [3:0]  pfl = '0;
    logic [31:0] eres [2] = '{32'd0, 32'd0};
    logic [3:0]  efl  [2] = '{4'd0, 4'd0};

    // Per-cycle drive values and observations.
    bit          d_v0 = 0, d_v1 = 0, d_rr0 = 0, d_rr1 = 0;
    logic [31:0] d_a0 = '0, d_b0 = '0, d_a1 = '0, d_b1 = '0;
    logic [2:0]  d_c0 = '0, d_c1 = '0;
    bit          obs_v0, obs_v1, obs_r0, obs_r1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        busy = 0; rr = 0; ea = '0; eb = '0; ec = '0;
        eres[0] = '0; eres[1] = '0; efl[0] = '0; efl[1] = '0;
    endtask

    task automatic apply_inputs();
        req0_valid = d_v0; req0_a = d_a0; req0_b = d_b0; req0_ctrl = d_c0; resp0_ready = d_rr0;
        req1_valid = d_v1; req1_a = d_a1; req1_b = d_b1; req1_ctrl = d_c1; resp1_ready = d_rr1;
    endtask

    // One clock: check registered outputs, apply inputs, check grant, advance model.
    task automatic tick();
        logic        g0, g1;
        logic [31:0] a, b;
        logic [2:0]  c;
        logic [35:0] rv;
        @(negedge clk);
        cyc++;
        if (busy && cyc == resp_t) begin
            eres[own] = pres;
            efl[own]  = pfl;
        end
        obs_v0 = resp0_valid;
        obs_v1 = resp1_valid;
        check("alu_a", alu_a, ea);
        check("alu_b", alu_b, eb);
        check("alu_ctrl", alu_ctrl, ec);
        check("resp0_valid", resp0_valid, busy && cyc >= resp_t && !own);
        check("resp1_valid", resp1_valid, busy && cyc >= resp_t && own);
        check("resp0_result", resp0_result, eres[0]);
        check("resp0_flags", resp0_flags, efl[0]);
        check("resp1_result", resp1_result, eres[1]);
        check("resp1_flags", resp1_flags, efl[1]);

        reset = 1'b0;
        apply_inputs();
        #1;
        g0 = 1'b0; g1 = 1'b0;
        if (!busy) begin
            if (d_v0 && d_v1) begin g0 = !rr; g1 = rr; end
            else begin g0 = d_v0; g1 = d_v1; end
        end
        obs_r0 = req0_ready;
        obs_r1 = req1_ready;
        check("req0_ready", req0_ready, g0);
        check("req1_ready", req1_ready, g1);

        if (busy && cyc >= resp_t) begin
            if (own ? d_rr1 : d_rr0) busy = 0;
        end else if (g0 || g1) begin
            own = g1; rr = !g1; busy = 1; acc_cyc = cyc;
            a = g1 ? d_a1 : d_a0;
            b = g1 ? d_b1 : d_b0;
            c = g1 ? d_c1 : d_c0;
            if (c > 3'd4) begin
                pres = '0; pfl = 4'b1000; resp_t = cyc + 1;
            end else begin
                ea = a; eb = b; ec = c;
                rv = alu_fn(a, b, c);
                pres = rv[31:0]; pfl = rv[35:32];
                resp_t = cyc + int'((c == 3'd4) ? MUL_SETTLE : SETTLE) + 1;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        cyc++;
        d_v0 = 0; d_v1 = 0; d_rr0 = 0; d_rr1 = 0;
        apply_inputs();
        reset = 1'b1;
        model_reset();
    endtask

    task automatic wait_resp(input bit port, output int lat);
        bit seen;
        seen = 0;
        lat  = -1;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (port ? obs_v1 : obs_v0) begin
                seen = 1;
                lat  = cyc - acc_cyc;
            end
        end
        check("resp_timeout", seen, 1);
    endtask

    function automatic logic [2:0] rand_ctrl();
        logic [2:0] c;
        c = 3'($urandom_range(0, 7));
        if (c == 3'd4 && $urandom_range(0, 3) != 0) c = 3'd0;
        return c;
    endfunction

    function automatic logic [31:0] rand_opnd();
        return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
    endfunction

    initial begin
        int lat, held, cnt;
        bit seen;
        reset = 1'b1;
        apply_inputs();
        repeat (3) @(negedge clk);

        // Reset values.
        tick();
        check("rst_ready", {req1_ready, req0_ready}, 2'b00);

        // Single ADD on port 0.
        d_v0 = 1; d_a0 = 32'd2; d_b0 = 32'd5; d_c0 = 3'd0;
        tick();
        check("add_accept", obs_r0, 1);
        tick();
        check("add_ready_pulse", obs_r0, 0);
        d_v0 = 0;
        wait_resp(0, lat);
        check("add_latency", lat, 5);
        check("add_result", resp0_result, 32'd7);
        check("add_flags", resp0_flags, 4'b0000);
        d_rr0 = 1; tick(); d_rr0 = 0; tick();

        // Simultaneous requests after reset: port 0 first, then port 1.
        pulse_reset();
        tick();
        d_v0 = 1; d_a0 = 32'd10; d_b0 = 32'd10; d_c0 = 3'd1;
        d_v1 = 1; d_a1 = 32'h8000000A; d_b1 = 32'h0000000C; d_c1 = 3'd2;
        tick();
        check("pair_grant0", {obs_r1, obs_r0}, 2'b01);
        d_v0 = 0;
        wait_resp(0, lat);
        check("sub_result", resp0_result, 32'd0);
        check("sub_flags", resp0_flags, 4'b0001);
        d_rr0 = 1; tick();
        check("pair_hold1", obs_r1, 0);
        d_rr0 = 0; tick();
        check("pair_grant1", obs_r1, 1);
        d_v1 = 0;
        wait_resp(1, lat);
        check("xor_result", resp1_result, 32'h80000006);
        d_rr1 = 1; tick(); d_rr1 = 0;

        // Two back-to-back simultaneous pairs alternate owners.
        d_v0 = 1; d_a0 = 32'd100; d_b0 = 32'd1; d_c0 = 3'd0;
        d_v1 = 1; d_a1 = 32'd3;   d_b1 = 32'd9; d_c1 = 3'd3;
        tick();
        check("alt_first", {obs_r1, obs_r0}, 2'b01);
        wait_resp(0, lat);
        d_rr0 = 1; tick(); d_rr0 = 0; tick();
        check("alt_second", {obs_r1, obs_r0}, 2'b10);
        d_v0 = 0; d_v1 = 0;
        wait_resp(1, lat);
        check("slt_result", resp1_result, 32'd1);
        d_rr1 = 1; tick(); d_rr1 = 0;

        // MUL on port 1 holds the ALU for the long window.
        d_v1 = 1; d_a1 = 32'd6; d_b1 = 32'hFFFFFFFD; d_c1 = 3'd4;
        tick();
        check("mul_accept", obs_r1, 1);
        d_v1 = 0;
        held = 0; seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            tick();
            if (obs_v1) seen = 1;
            else if (alu_ctrl === 3'b100) held++;
        end
        check("mul_timeout", seen, 1);
        check("mul_hold", held, 40);
        check("mul_latency", cyc - acc_cyc, 41);
        check("mul_result", resp1_result, 32'hFFFFFFEE);
        d_rr1 = 1; tick(); d_rr1 = 0;

        // Illegal op answers next cycle and leaves the ALU inputs alone.
        d_v0 = 1; d_a0 = 32'h1234; d_b0 = 32'h5678; d_c0 = 3'd7;
        tick();
        d_v0 = 0;
        wait_resp(0, lat);
        check("ill_latency", lat, 1);
        check("ill_result", resp0_result, 32'd0);
        check("ill_flags", resp0_flags, 4'b1000);
        check("ill_alu_a", alu_a, 32'd6);
        check("ill_alu_ctrl", alu_ctrl, 3'b100);
        d_rr0 = 1; tick(); d_rr0 = 0;

        // Response back-pressure blocks the other port until after the handshake.
        d_v0 = 1; d_a0 = 32'd100; d_b0 = 32'd23; d_c0 = 3'd0;
        tick();
        d_v0 = 0;
        wait_resp(0, lat);
        d_v1 = 1; d_a1 = 32'hF0F0F0F0; d_b1 = 32'h0F0F0F0F; d_c1 = 3'd2;
        cnt = 0;
        repeat (10) begin
            tick();
            if (obs_r1) cnt++;
        end
        check("bp_no_ready1", cnt, 0);
        check("bp_result_stable", resp0_result, 32'd123);
        d_rr0 = 1; tick();
        check("bp_hs_ready1", obs_r1, 0);
        d_rr0 = 0; tick();
        check("bp_after_ready1", obs_r1, 1);
        d_v1 = 0;
        wait_resp(1, lat);
        check("bp_xor_result", resp1_result, 32'hFFFFFFFF);
        d_rr1 = 1; tick(); d_rr1 = 0;

        // Reset during DRIVE abandons the op.
        d_v0 = 1; d_a0 = 32'd40; d_b0 = 32'd2; d_c0 = 3'd0;
        tick();
        d_v0 = 0;
        tick();
        pulse_reset();
        tick();
        check("abort_alu_a", alu_a, 32'd0);
        cnt = 0;
        d_rr0 = 1; d_rr1 = 1;
        repeat (10) begin
            tick();
            if (obs_v0 || obs_v1) cnt++;
        end
        check("abort_no_resp", cnt, 0);
        d_rr0 = 0; d_rr1 = 0;

        // Randomized traffic on both ports with random response back-pressure.
        for (int i = 0; i < 1500; i++) begin
            d_v0 = ($urandom_range(0, 1) == 1);
            d_v1 = ($urandom_range(0, 1) == 1);
            d_a0 = rand_opnd(); d_b0 = rand_opnd(); d_c0 = rand_ctrl();
            d_a1 = rand_opnd(); d_b1 = rand_opnd(); d_c1 = rand_ctrl();
            d_rr0 = ($urandom_range(0, 3) != 0);
            d_rr1 = ($urandom_range(0, 3) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Two-port, time-multiplexing controller for the 32-bit gate-level MIPS-style ALU.
- The ALU is purely combinational and needs many gate delays to settle.
- This block arbitrates between two requesters, registers the winner's operands and control code, and holds them on the ALU inputs for a programmable number of settle cycles.
- It then captures result and flags and returns them over a valid/ready response channel.

Parameters:
- WIDTH, 32, operand/result width.
- SETTLE, 4, clock cycles operands are held before capture for ADD/SUB/XOR/SLT (must be >= 1).
- MUL_SETTLE, 40, clock cycles operands are held before capture for MUL (must be >= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle when high with req0_valid.
- req0_a  input  WIDTH  operand A.
- req0_b  input  WIDTH  operand B.
- req0_ctrl  input  3  ALU op: 000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 MUL.
- resp0_valid  output  1  response for requester 0 available.
- resp0_ready  input  1  requester 0 takes response.
- resp0_result  output  WIDTH  captured ALU result.
- resp0_flags  output  4  {err, cout, overflow, zero}.
- req1_valid, req1_ready, req1_a, req1_b, req1_ctrl, resp1_valid, resp1_ready, resp1_result, resp1_flags: identical to port 0, for requester 1.
- alu_a  output  WIDTH  to ALU A.
- alu_b  output  WIDTH  to ALU B.
- alu_ctrl  output  3  to ALU Ctrl.
- alu_out  input  WIDTH  ALU FinalOut.
- alu_zero  input  1  ALU zero.
- alu_overflow  input  1  ALU overflow.
- alu_cout  input  1  ALU CoutFinal.

Behaviour:
- Reset values:
  - State IDLE; rr pointer = 0; counter = 0.
  - alu_a, alu_b, alu_ctrl = 0.
  - All req*_ready = 0 and all resp*_valid = 0.
  - resp*_result and resp*_flags = 0.
  - Reset mid-operation abandons the in-flight op; no response is produced.
- States: IDLE, DRIVE, RESP.
- IDLE, grant:
  - Grant is combinational. reqN_ready = 1 only for the granted requester, only in IDLE.
  - Only one valid requester: that requester is granted.
  - Both valid: the requester equal to the rr pointer is granted.
- IDLE, on accept:
  - Register a, b, ctrl onto alu_a/alu_b/alu_ctrl and record the owner.
  - Set rr pointer to the non-owner.
  - Legal ctrl: load counter with (MUL_SETTLE if ctrl==100 else SETTLE) - 1 and go to DRIVE.
  - Illegal ctrl (101/110/111): do not change the alu_* outputs. Go directly to RESP with result = 0 and flags = 1000 (err set).
- DRIVE:
  - alu_* are held constant.
  - Counter decrements each cycle.
  - On the edge where counter == 0: capture result = alu_out and flags = {0, alu_cout, alu_overflow, alu_zero} into the owner's resp registers, then go to RESP.
- RESP:
  - respN_valid = 1 for the owner only. Result and flags are stable while valid.
  - On respN_valid & respN_ready: clear valid and go to IDLE.
  - A new request can be accepted in the cycle after the handshake, not the same cycle.
- Latency:
  - Accept at edge k.
  - ALU inputs change after edge k and stay stable for SETTLE (or MUL_SETTLE) cycles.
  - resp_valid goes high after edge k+SETTLE: SETTLE+1 cycles from accept to the first valid-high cycle.
  - Illegal op: resp_valid goes high the cycle after accept.
- After RESP, alu_* keep their last values and are not re-zeroed.
- The non-owner's ready and resp_valid stay 0 throughout. Its request waits, with no starvation because of rr.
- A requester asserting valid with the same payload back-to-back is serviced once per accept.
- No width truncation is done here. The result is the ALU's 32-bit output verbatim, and the MUL overflow flag is passed through as-is.

Test Plan:
- Reset, then req0 ADD a=2 b=5, SETTLE=4, ALU model delayed by 3 cycles -> req0_ready pulses 1 cycle; resp0_valid asserts 5 cycles after accept; result 7; flags 0000.
- req0 and req1 both valid after reset (req0 SUB 10-10, req1 XOR 0x8000000A^0x0000000C) -> req0 served first with result 0 and flags 0001. Then req1 served with result 0x80000006. rr alternates on the next simultaneous pair.
- req1 MUL a=6 b=-3, MUL_SETTLE=40 -> alu_ctrl = 100 held for exactly 40 cycles; resp1_result = 0xFFFFFFEE.
- req0 ctrl=111 -> resp0_valid the next cycle; result 0; flags 1000; alu_* unchanged.
- resp0_ready held low for 10 cycles -> resp0_valid and result remain stable; req1_valid during that window sees req1_ready = 0 until one cycle after the resp0 handshake.
- reset asserted in cycle 2 of DRIVE -> all outputs return to reset values next edge; no response is ever presented for the aborted op.
